// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared definitions for the I2C slave data-path engines.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam logic SYNC_RESET_LEVEL = 1'b1;

    typedef logic [1:0] i2c_state_t;

    localparam i2c_state_t c_ST_IDLE      = 2'd0;
    localparam i2c_state_t c_ST_RECV      = 2'd1;
    localparam i2c_state_t c_ST_ACK_SETUP = 2'd2;
    localparam i2c_state_t c_ST_ACK_DRIVE = 2'd3;

    // Wide enough to hold the value DATA_WIDTH itself.
    function automatic int bit_cnt_width(input int data_width);
        return (data_width < 1) ? 1 : $clog2(data_width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : SCL/SDA synchronisers with SCL edge and START/STOP detection.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("i2c_bus_sync: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl_s;
    logic                   w_sda_s;

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

    // Idle-bus reset level so no spurious edge appears when reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= {SYNC_STAGES{SYNC_RESET_LEVEL}};
            r_sda_sync <= {SYNC_STAGES{SYNC_RESET_LEVEL}};
            r_scl_prev <= SYNC_RESET_LEVEL;
            r_sda_prev <= SYNC_RESET_LEVEL;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
        end
    end

    assign o_sda      = w_sda_s;
    assign o_scl_rise = w_scl_s & ~r_scl_prev;
    assign o_scl_fall = ~w_scl_s & r_scl_prev;
    assign o_start    = w_scl_s & r_scl_prev & r_sda_prev & ~w_sda_s;
    assign o_stop     = w_scl_s & r_scl_prev & ~r_sda_prev & w_sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_read_word.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_read_word
// Description : I2C slave receive engine: shifts in one word, optional ACK bit.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_read_word
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_EN      = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  ack,
    input  logic                  scl,
    input  logic                  sda,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  sda_drive_low,
    output logic                  ack_done,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  abort
);

    generate
        if (DATA_WIDTH < 1) begin : g_bad_data_width
            $error("i2c_slave_read_word: DATA_WIDTH must be >= 1");
        end
    endgenerate

    localparam int                CNT_W      = bit_cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  c_LAST_CNT = CNT_W'(DATA_WIDTH);

    logic w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop, w_bus_event;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk        (clock),
        .rst        (reset),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_sda      (w_sda_s),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_bus_event = w_start | w_stop;

    i2c_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_bit_cnt, w_cnt_nxt, w_cnt_inc;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_drive, w_drive_nxt;
    logic                  r_ack_done, w_ack_done_nxt;
    logic                  r_abort, w_abort_nxt;
    logic                  r_start_det, r_stop_det;

    assign w_cnt_inc = r_bit_cnt + CNT_W'(1);
    assign w_shifted = (r_shift << 1) | DATA_WIDTH'(w_sda_s);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_drive     <= 1'b0;
            r_ack_done  <= 1'b0;
            r_abort     <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_drive     <= w_drive_nxt;
            r_ack_done  <= w_ack_done_nxt;
            r_abort     <= w_abort_nxt;
            r_start_det <= w_start;
            r_stop_det  <= w_stop;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_drive_nxt    = r_drive;
        w_ack_done_nxt = 1'b0;
        w_abort_nxt    = 1'b0;
        // A bus START/STOP outranks any SCL edge seen in the same cycle.
        if (r_state != c_ST_IDLE && w_bus_event) begin
            w_state_nxt = c_ST_IDLE;
            w_drive_nxt = 1'b0;
            w_abort_nxt = 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (go) begin
                        w_state_nxt = c_ST_RECV;
                        w_cnt_nxt   = '0;
                    end
                end
                c_ST_RECV: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_shifted;
                        w_cnt_nxt   = w_cnt_inc;
                        if (w_cnt_inc == c_LAST_CNT) begin
                            w_data_nxt  = w_shifted;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = (ACK_EN != 0) ? c_ST_ACK_SETUP : c_ST_IDLE;
                        end
                    end
                end
                c_ST_ACK_SETUP: begin
                    if (w_scl_fall) begin
                        w_state_nxt = c_ST_ACK_DRIVE;
                        w_drive_nxt = ack;
                    end
                end
                c_ST_ACK_DRIVE: begin
                    if (w_scl_fall) begin
                        w_state_nxt    = c_ST_IDLE;
                        w_drive_nxt    = 1'b0;
                        w_ack_done_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_drive_nxt = 1'b0;
                end
            endcase
        end
    end

    assign data          = r_data;
    assign data_valid    = r_valid;
    assign busy          = (r_state != c_ST_IDLE);
    assign sda_drive_low = r_drive;
    assign ack_done      = r_ack_done;
    assign start_det     = r_start_det;
    assign stop_det      = r_stop_det;
    assign abort         = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_read_word.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_read_word
// Description : Directed self-checking bench for i2c_slave_read_word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_read_word;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       go    = 1'b0;
    logic       go0   = 1'b0;
    logic       ack   = 1'b0;
    logic       scl   = 1'b1;
    logic       sda   = 1'b1;

    logic [7:0] data, data0;
    logic       data_valid, busy, sda_drive_low, ack_done, start_det, stop_det, abort;
    logic       data_valid0, busy0, sda_drive_low0, ack_done0, start_det0, stop_det0, abort0;

    int n_checks = 0;
    int n_fail   = 0;

    int n_valid = 0, n_ackd = 0, n_drive = 0, n_abort = 0;
    int n_start0 = 0, n_abort0 = 0;
    logic [7:0] words0[$];

    always #5 clock = ~clock;

    i2c_slave_read_word #(.DATA_WIDTH(8), .SYNC_STAGES(2), .ACK_EN(1)) dut (
        .clock(clock), .reset(reset), .go(go), .ack(ack), .scl(scl), .sda(sda),
        .data(data), .data_valid(data_valid), .busy(busy), .sda_drive_low(sda_drive_low),
        .ack_done(ack_done), .start_det(start_det), .stop_det(stop_det), .abort(abort)
    );

    i2c_slave_read_word #(.DATA_WIDTH(8), .SYNC_STAGES(2), .ACK_EN(0)) dut0 (
        .clock(clock), .reset(reset), .go(go0), .ack(ack), .scl(scl), .sda(sda),
        .data(data0), .data_valid(data_valid0), .busy(busy0), .sda_drive_low(sda_drive_low0),
        .ack_done(ack_done0), .start_det(start_det0), .stop_det(stop_det0), .abort(abort0)
    );

    always @(negedge clock) begin
        if (!reset) begin
            if (data_valid)    n_valid++;
            if (ack_done)      n_ackd++;
            if (sda_drive_low) n_drive++;
            if (abort)         n_abort++;
            if (start_det0)    n_start0++;
            if (abort0)        n_abort0++;
            if (data_valid0)   words0.push_back(data0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda = b;  cyc(4);
        scl = 1'b1; cyc(8);
        scl = 1'b0; cyc(4);
    endtask

    task automatic send_byte(input logic [7:0] v, input int nbits);
        logic [7:0] t;
        t = v;
        for (int i = 0; i < nbits; i++) send_bit(t[7-i]);
    endtask

    task automatic ack_clock();
        cyc(4); scl = 1'b1; cyc(8); scl = 1'b0; cyc(4);
    endtask

    task automatic bus_start();
        sda = 1'b1; cyc(4);
        scl = 1'b1; cyc(4);
        sda = 1'b0; cyc(4);
        scl = 1'b0; cyc(4);
    endtask

    task automatic bus_stop();
        sda = 1'b0; cyc(4);
        scl = 1'b1; cyc(4);
        sda = 1'b1; cyc(4);
    endtask

    task automatic pulse_go();
        go = 1'b1; cyc(1); go = 1'b0;
    endtask

    task automatic test_reset();
        int v0;
        reset = 1'b1; cyc(3); reset = 1'b0; cyc(4);
        n_checks++;
        if ({data, data_valid, busy, sda_drive_low, ack_done, start_det, stop_det, abort} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {data, data_valid, busy, sda_drive_low, ack_done, start_det, stop_det, abort});
        end
        bus_start();
        pulse_go();
        send_byte(8'hA5, 3);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid_recv: got %b expected 1", busy); end
        reset = 1'b1; cyc(1);
        n_checks++;
        if ({data, data_valid, busy, sda_drive_low, ack_done, start_det, stop_det, abort} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_mid_recv: got %h expected 0000",
                     {data, data_valid, busy, sda_drive_low, ack_done, start_det, stop_det, abort});
        end
        reset = 1'b0; cyc(4);
        ack = 1'b1;
        bus_start();
        v0 = n_valid;
        pulse_go();
        send_byte(8'hA5, 8);
        ack_clock();
        n_checks++;
        if (data !== 8'hA5) begin n_fail++; $display("FAIL data_after_reset: got %h expected a5", data); end
        n_checks++;
        if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL valid_count_a5: got %0d expected 1", n_valid - v0); end
    endtask

    task automatic test_ack();
        int v0, a0;
        bus_stop(); bus_start();
        ack = 1'b1;
        v0 = n_valid; a0 = n_ackd;
        pulse_go();
        send_byte(8'h3C, 7);
        sda = 1'b0; cyc(4);
        scl = 1'b1; cyc(2);
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL valid_early: got %b expected 0", data_valid); end
        cyc(1);
        n_checks++;
        if ({data_valid, data} !== {1'b1, 8'h3C}) begin
            n_fail++; $display("FAIL valid_data_3c: got %b/%h expected 1/3c", data_valid, data);
        end
        cyc(5);
        scl = 1'b0; cyc(2);
        n_checks++;
        if (sda_drive_low !== 1'b0) begin n_fail++; $display("FAIL drive_early: got %b expected 0", sda_drive_low); end
        cyc(1);
        n_checks++;
        if (sda_drive_low !== 1'b1) begin n_fail++; $display("FAIL drive_on_8th_fall: got %b expected 1", sda_drive_low); end
        cyc(1);
        cyc(4); scl = 1'b1; cyc(8);
        n_checks++;
        if (sda_drive_low !== 1'b1) begin n_fail++; $display("FAIL drive_scl_high: got %b expected 1", sda_drive_low); end
        scl = 1'b0; cyc(2);
        n_checks++;
        if ({sda_drive_low, ack_done} !== 2'b10) begin
            n_fail++; $display("FAIL drive_before_9th_fall: got %b expected 10", {sda_drive_low, ack_done});
        end
        cyc(1);
        n_checks++;
        if ({sda_drive_low, ack_done} !== 2'b01) begin
            n_fail++; $display("FAIL ack_done_9th_fall: got %b expected 01", {sda_drive_low, ack_done});
        end
        cyc(1);
        n_checks++;
        if ({ack_done, busy} !== 2'b00) begin n_fail++; $display("FAIL ack_done_once: got %b expected 00", {ack_done, busy}); end
        n_checks++;
        if ({n_valid - v0, n_ackd - a0} !== {32'd1, 32'd1}) begin
            n_fail++; $display("FAIL counts_3c: got valid %0d ackd %0d expected 1 1", n_valid - v0, n_ackd - a0);
        end
    endtask

    task automatic test_nack();
        int v0, a0, d0;
        bus_stop(); bus_start();
        ack = 1'b0;
        v0 = n_valid; a0 = n_ackd; d0 = n_drive;
        pulse_go();
        send_byte(8'hFF, 8);
        ack_clock();
        n_checks++;
        if (n_drive - d0 !== 0) begin n_fail++; $display("FAIL nack_drive: got %0d cycles expected 0", n_drive - d0); end
        n_checks++;
        if (n_ackd - a0 !== 1) begin n_fail++; $display("FAIL nack_ack_done: got %0d expected 1", n_ackd - a0); end
        n_checks++;
        if ({n_valid - v0 == 1, data} !== {1'b1, 8'hFF}) begin
            n_fail++; $display("FAIL nack_data: got %0d/%h expected 1/ff", n_valid - v0, data);
        end
    endtask

    task automatic test_stop_abort();
        int v0, a0, b0;
        bus_stop(); bus_start();
        ack = 1'b1;
        v0 = n_valid; a0 = n_ackd; b0 = n_abort;
        pulse_go();
        send_byte(8'hC3, 5);
        sda = 1'b0; cyc(4);
        scl = 1'b1; cyc(4);
        sda = 1'b1; cyc(2);
        n_checks++;
        if ({stop_det, abort, busy} !== 3'b001) begin
            n_fail++; $display("FAIL stop_early: got %b expected 001", {stop_det, abort, busy});
        end
        cyc(1);
        n_checks++;
        if ({stop_det, abort} !== 2'b11) begin n_fail++; $display("FAIL stop_abort: got %b expected 11", {stop_det, abort}); end
        cyc(1);
        n_checks++;
        if ({stop_det, abort, busy} !== 3'b000) begin
            n_fail++; $display("FAIL stop_after: got %b expected 000", {stop_det, abort, busy});
        end
        n_checks++;
        if (data !== 8'hFF) begin n_fail++; $display("FAIL stop_data_kept: got %h expected ff", data); end
        n_checks++;
        if ({n_valid - v0, n_ackd - a0, n_abort - b0} !== {32'd0, 32'd0, 32'd1}) begin
            n_fail++; $display("FAIL stop_counts: got valid %0d ackd %0d abort %0d expected 0 0 1",
                               n_valid - v0, n_ackd - a0, n_abort - b0);
        end
    endtask

    task automatic test_start_in_ack_setup();
        int v0, a0, d0;
        bus_start();
        ack = 1'b1;
        v0 = n_valid; a0 = n_ackd; d0 = n_drive;
        pulse_go();
        send_byte(8'h81, 7);
        sda = 1'b1; cyc(4);
        scl = 1'b1; cyc(6);
        n_checks++;
        if ({busy, n_valid - v0 == 1, data} !== {2'b11, 8'h81}) begin
            n_fail++; $display("FAIL ack_setup_entry: got busy %b valid %0d data %h expected 1 1 81", busy, n_valid - v0, data);
        end
        sda = 1'b0; cyc(2);
        n_checks++;
        if (start_det !== 1'b0) begin n_fail++; $display("FAIL rstart_early: got %b expected 0", start_det); end
        cyc(1);
        n_checks++;
        if ({start_det, abort} !== 2'b11) begin n_fail++; $display("FAIL rstart_abort: got %b expected 11", {start_det, abort}); end
        scl = 1'b0; cyc(8);
        n_checks++;
        if ({n_drive - d0, n_ackd - a0} !== {32'd0, 32'd0} || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstart_after: got drive %0d ackd %0d busy %b expected 0 0 0", n_drive - d0, n_ackd - a0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int s0, b0, w0;
        bus_stop();
        s0 = n_start0; b0 = n_abort0;
        bus_start();
        n_checks++;
        if ({n_start0 - s0, n_abort0 - b0} !== {32'd1, 32'd0} || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL idle_start: got start %0d abort %0d busy %b expected 1 0 0", n_start0 - s0, n_abort0 - b0, busy0);
        end
        w0 = words0.size();
        go0 = 1'b1; cyc(1);
        send_byte(8'h12, 8);
        send_byte(8'h34, 8);
        go0 = 1'b0; cyc(2);
        n_checks++;
        if (words0.size() - w0 !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 2", words0.size() - w0);
        end else begin
            n_checks++;
            if ({words0[w0], words0[w0+1]} !== 16'h1234) begin
                n_fail++; $display("FAIL b2b_words: got %h %h expected 12 34", words0[w0], words0[w0+1]);
            end
        end
        n_checks++;
        if (data0 !== 8'h34) begin n_fail++; $display("FAIL b2b_data_hold: got %h expected 34", data0); end
        bus_stop();
    endtask

    initial begin
        test_reset();
        test_ack();
        test_nack();
        test_stop_abort();
        test_start_in_ack_setup();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave_read_word.md
Name: i2c_slave_read_word

Overview:
- Parametrised I2C slave receive engine for the slave data path.
- Shifts in one DATA_WIDTH-bit word MSB-first on SCL rising edges and presents it with a one-cycle valid strobe.
- Optionally drives the ACK/NACK bit on the following SCL clock.
- Synchronises raw SCL/SDA internally, detects START/STOP, and aborts a transfer cleanly on either; sits under the slave byte/address FSM.

Parameters:
- DATA_WIDTH, 8: bits per word, must be >= 1.
- SYNC_STAGES, 2: flops in each SCL/SDA synchroniser, must be >= 2.
- ACK_EN, 1: 1 = run an ACK phase after the last bit; 0 = finish right after the last bit.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- go  input  1  level; starts reception when sampled high in IDLE, ignored otherwise.
- ack  input  1  sampled at ACK-phase entry; 1 = ACK (drive low), 0 = NACK (release).
- scl  input  1  raw bus SCL.
- sda  input  1  raw bus SDA.
- data  output  DATA_WIDTH  received word, held until next data_valid or reset.
- data_valid  output  1  one-cycle pulse, data is new.
- busy  output  1  high in any state other than IDLE.
- sda_drive_low  output  1  1 = pull SDA low (to open-drain pad).
- ack_done  output  1  one-cycle pulse when the ACK phase completes.
- start_det  output  1  one-cycle pulse on START, in every state.
- stop_det  output  1  one-cycle pulse on STOP, in every state.
- abort  output  1  one-cycle pulse when START/STOP ends an active transfer.

Behaviour:
- Clock and reset: one clock domain (clock). Reset is synchronous, active-high, and wins over every other input in the same cycle.
- Reset values:
  - all outputs 0;
  - synchroniser chains and previous-sample flops set to 1 (bus idle, so no false edge after reset);
  - state IDLE, bit_cnt 0, shift register 0.
- Synchroniser: scl_s/sda_s are the last stage of each chain.
  - scl_rise = scl_s & !scl_prev; scl_fall = !scl_s & scl_prev.
  - START = scl_s & scl_prev & sda_prev & !sda_s; STOP = scl_s & scl_prev & !sda_prev & sda_s.
  - Pin-to-detect latency is SYNC_STAGES+1 clocks.
- IDLE:
  - go=1 -> RECV, bit_cnt<=0.
  - An scl_rise in the same cycle as go is not sampled; the first bit is taken on the next rise.
- RECV:
  - On scl_rise: shift <= {shift[DATA_WIDTH-2:0], sda_s}; bit_cnt++ (counter width $clog2(DATA_WIDTH+1)).
  - On the rise that makes bit_cnt == DATA_WIDTH: next cycle data <= word, data_valid=1.
  - Then state -> ACK_SETUP if ACK_EN, else IDLE.
- ACK_SETUP: on scl_fall -> ACK_DRIVE, sda_drive_low <= ack in the same registered update.
- ACK_DRIVE:
  - Hold sda_drive_low through the SCL high phase.
  - On the next scl_fall: sda_drive_low<=0, ack_done=1, -> IDLE.
- Abort:
  - START or STOP in RECV, ACK_SETUP or ACK_DRIVE -> abort=1 and IDLE in the next cycle.
  - sda_drive_low<=0, no data_valid, no ack_done; data keeps its previous value.
  - Abort has priority over a same-cycle scl_rise or scl_fall. start_det/stop_det still pulse.
- In IDLE, START/STOP pulse start_det/stop_det only; abort stays 0.
- Back-to-back words: go held high re-arms in the cycle after returning to IDLE. With ACK_EN=0 the next word's first bit is the next scl_rise.
- DATA_WIDTH=1 is legal: the first rise completes the word.
- Parameter violation (DATA_WIDTH<1 or SYNC_STAGES<2) is a elaboration-time error.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enumeration (IDLE, RECV, ACK_SETUP, ACK_DRIVE);
  - localparam SYNC_RESET_LEVEL=1'b1;
  - the bit-counter width function.
- One sub-module, i2c_bus_sync: SCL/SDA synchroniser chains, scl_rise/scl_fall and START/STOP detection, parametrised by SYNC_STAGES.
- Reusable by the slave write-bit/write-word blocks.

Test Plan:
1. Reset mid-RECV after 3 bits, then release -> all outputs 0. A new go plus byte 0xA5 gives data=0xA5 and exactly one data_valid.
2. ACK_EN=1, ack=1, byte 0x3C -> data_valid one cycle after the 8th rise with data=0x3C. sda_drive_low=1 from the 8th scl_fall to the 9th scl_fall, then ack_done=1.
3. ack=0 with byte 0xFF -> sda_drive_low stays 0 through the 9th clock; ack_done still pulses once.
4. STOP after 5 bits of 0xC3 -> stop_det=1 and abort=1 in the same cycle. No data_valid; data keeps the prior word; busy=0 next cycle.
5. Repeated START during ACK_SETUP -> start_det=1, abort=1, sda_drive_low never asserts.
6. ACK_EN=0, go held high, words 0x12 then 0x34 back to back -> two data_valid pulses with data 0x12 then 0x34, no dropped bit. A glitch-free START in IDLE pulses start_det only.
